// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared state type and AXI constants for the burst arbiter
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        WRESP
    } arb_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         ID_W           = 4;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - cyclic first-requester picker; ptr_i = 0 gives fixed lowest-index priority
module arb_pick #(
    parameter int NM = 2,
    parameter int IW = 1
) (
    input  logic [NM-1:0] req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [NM-1:0] grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] sel;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        sel     = '0;
        for (int off = 0; off < NM; off++) begin
            sel = IW'((int'(ptr_i) + off) % NM);
            if (!valid_o && req_i[sel]) begin
                valid_o      = 1'b1;
                grant_o[sel] = 1'b1;
                idx_o        = sel;
            end
        end
    end

endmodule

// File: rtl/axi_burst_arbiter.sv
// rtl/axi_burst_arbiter.sv - whole-burst arbiter sharing one AXI bridge among cache masters
// ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise fixed lowest-index priority.
module axi_burst_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NM = 2,
    parameter int LW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM-1:0]    m_req_i,
    input  logic [NM-1:0]    m_wr_i,
    input  logic [NM*32-1:0] m_addr_i,
    input  logic [NM*LW-1:0] m_len_i,
    input  logic [NM*3-1:0]  m_size_i,
    input  logic [NM*32-1:0] m_wdata_i,
    input  logic [NM*4-1:0]  m_wstrb_i,
    output logic [NM-1:0]    m_addr_ok_o,
    output logic [NM-1:0]    m_data_ok_o,
    output logic [NM-1:0]    m_wb_ok_o,
    output logic [31:0]      m_rdata_o,
    output logic             s_req_o,
    output logic             s_wr_o,
    output logic [31:0]      s_addr_o,
    output logic [31:0]      s_wdata_o,
    output logic [LW-1:0]    s_len_o,
    output logic [2:0]       s_size_o,
    output logic [1:0]       s_burst_o,
    output logic [3:0]       s_wstrb_o,
    output logic             s_wlast_o,
    output logic             s_awvalid_o,
    output logic [ID_W-1:0]  s_rid_o,
    input  logic             s_addr_ok_i,
    input  logic             s_data_ok_i,
    input  logic             s_wb_ok_i,
    input  logic [31:0]      s_rdata_i
);

    localparam int IW = (NM > 2) ? 2 : 1;

    arb_state_t    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          wr_q, wr_d;
    logic [LW-1:0] len_q, len_d;
    logic [2:0]    size_q, size_d;
    logic [31:0]   addr_q, addr_d;
    logic [LW-1:0] cnt_q, cnt_d;

    logic [IW-1:0] ptr;
    logic [NM-1:0] pick_grant;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic          done;

    // A transaction ends on the last read beat or on the write response.
    assign done = (state_q == DATA && s_data_ok_i && !wr_q && cnt_q == len_q) ||
                  (state_q == WRESP && s_wb_ok_i);
    assign ptr  = rr_ptr_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (done) begin
            rr_ptr_d = (int'(owner_q) == NM - 1) ? '0 : owner_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end
`else
    assign ptr = '0;
`endif

    arb_pick #(.NM(NM), .IW(IW)) u_pick (
        .req_i   (m_req_i),
        .ptr_i   (ptr),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            wr_q    <= 1'b0;
            len_q   <= '0;
            size_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        len_d       = len_q;
        size_d      = size_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        m_addr_ok_o = '0;
        m_data_ok_o = '0;
        m_wb_ok_o   = '0;
        s_req_o     = 1'b0;
        s_wr_o      = 1'b0;
        s_awvalid_o = 1'b0;
        s_wlast_o   = 1'b0;
        s_wdata_o   = '0;
        s_wstrb_o   = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    wr_d    = |(m_wr_i & pick_grant);
                    len_d   = m_len_i[int'(pick_idx)*LW +: LW];
                    size_d  = m_size_i[int'(pick_idx)*3 +: 3];
                    addr_d  = m_addr_i[int'(pick_idx)*32 +: 32];
                    state_d = ADDR;
                end
            end
            ADDR: begin
                s_req_o     = 1'b1;
                s_wr_o      = wr_q;
                s_awvalid_o = wr_q;
                if (s_addr_ok_i) begin
                    m_addr_ok_o[owner_q] = 1'b1;
                    cnt_d                = '0;
                    state_d              = DATA;
                end
            end
            DATA: begin
                // The bridge only raises wvalid while req and wr are both high.
                s_req_o   = wr_q;
                s_wr_o    = wr_q;
                s_wlast_o = wr_q && (cnt_q == len_q);
                if (wr_q) begin
                    s_wdata_o = m_wdata_i[int'(owner_q)*32 +: 32];
                    s_wstrb_o = m_wstrb_i[int'(owner_q)*4 +: 4];
                end
                if (s_data_ok_i) begin
                    m_data_ok_o[owner_q] = 1'b1;
                    if (cnt_q == len_q) begin
                        if (wr_q) begin
                            state_d = WRESP;
                        end else begin
                            m_wb_ok_o[owner_q] = 1'b1;
                            state_d            = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WRESP: begin
                s_req_o = 1'b1;
                s_wr_o  = 1'b1;
                if (s_wb_ok_i) begin
                    m_wb_ok_o[owner_q] = 1'b1;
                    state_d            = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_rdata_o = s_rdata_i;
    assign s_addr_o  = addr_q;
    assign s_len_o   = len_q;
    assign s_size_o  = size_q;
    assign s_burst_o = AXI_BURST_INCR;
    assign s_rid_o   = ID_W'(owner_q);

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(s_data_ok_i && state_q == ADDR))
                else $error("bridge data_ok before address handshake");
            assert (!(s_wb_ok_i && state_q != WRESP))
                else $error("bridge wb_ok outside write response phase");
        end
    end
`endif

endmodule

// File: tb/tb_axi_burst_arbiter.sv
// tb/tb_axi_burst_arbiter.sv - randomized bench with bridge driver and arbitration reference model
module tb_axi_burst_arbiter;

    localparam int NM = 2;
    localparam int LW = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NM-1:0]    m_req_i = '0, m_wr_i = '0;
    logic [NM*32-1:0] m_addr_i = '0, m_wdata_i = '0;
    logic [NM*LW-1:0] m_len_i = '0;
    logic [NM*3-1:0]  m_size_i = '0;
    logic [NM*4-1:0]  m_wstrb_i = '0;
    logic [NM-1:0]    m_addr_ok_o, m_data_ok_o, m_wb_ok_o;
    logic [31:0]      m_rdata_o, s_addr_o, s_wdata_o;
    logic             s_req_o, s_wr_o, s_wlast_o, s_awvalid_o;
    logic [LW-1:0]    s_len_o;
    logic [2:0]       s_size_o;
    logic [1:0]       s_burst_o;
    logic [3:0]       s_wstrb_o, s_rid_o;
    logic             s_addr_ok_i = 1'b0, s_data_ok_i = 1'b0, s_wb_ok_i = 1'b0;
    logic [31:0]      s_rdata_i = '0;

    axi_burst_arbiter #(.NM(NM), .LW(LW)) dut (
        .clk(clk), .rst(rst),
        .m_req_i(m_req_i), .m_wr_i(m_wr_i), .m_addr_i(m_addr_i), .m_len_i(m_len_i),
        .m_size_i(m_size_i), .m_wdata_i(m_wdata_i), .m_wstrb_i(m_wstrb_i),
        .m_addr_ok_o(m_addr_ok_o), .m_data_ok_o(m_data_ok_o), .m_wb_ok_o(m_wb_ok_o),
        .m_rdata_o(m_rdata_o), .s_req_o(s_req_o), .s_wr_o(s_wr_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_len_o(s_len_o), .s_size_o(s_size_o), .s_burst_o(s_burst_o),
        .s_wstrb_o(s_wstrb_o), .s_wlast_o(s_wlast_o), .s_awvalid_o(s_awvalid_o),
        .s_rid_o(s_rid_o), .s_addr_ok_i(s_addr_ok_i), .s_data_ok_i(s_data_ok_i),
        .s_wb_ok_i(s_wb_ok_i), .s_rdata_i(s_rdata_i)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic          cfg_wr[NM];
    logic [31:0]   cfg_addr[NM];
    logic [LW-1:0] cfg_len[NM];
    logic [2:0]    cfg_size[NM];

    bit            obs_timeout;
    int            obs_spurious;
    logic [3:0]    obs_rid;
    logic          obs_wr, obs_awv;
    logic [31:0]   obs_addr;
    logic [LW-1:0] obs_len;
    logic [2:0]    obs_size;
    logic [NM-1:0] obs_aok, obs_wbok;

    logic [NM-1:0]    q_dok[$], q_wbok[$];
    logic             q_wlast[$], q_req[$];
    logic [31:0]      q_wd[$], q_rd[$], q_rdd[$];
    logic [NM*32-1:0] q_wdd[$];
    logic [3:0]       q_rid[$];

`ifdef ARB_ROUND_ROBIN_EN
    int model_ptr = 0;
`endif

    // Reference: first requester at/after the pointer in RR mode, lowest index otherwise.
    function automatic int exp_winner(input logic [NM-1:0] req);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < NM; k++) if (req[(model_ptr + k) % NM]) return (model_ptr + k) % NM;
`else
        for (int k = 0; k < NM; k++) if (req[k]) return k;
`endif
        return 0;
    endfunction

    function automatic logic [NM-1:0] onehot(input int w);
        logic [NM-1:0] v;
        v    = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    task automatic model_done(input int w);
`ifdef ARB_ROUND_ROBIN_EN
        model_ptr = (w + 1) % NM;
`endif
    endtask

    task automatic model_reset();
`ifdef ARB_ROUND_ROBIN_EN
        model_ptr = 0;
`endif
    endtask

    task automatic setm(input int i, input logic wr, input logic [31:0] addr,
                        input logic [LW-1:0] len, input logic [2:0] size);
        cfg_wr[i] = wr; cfg_addr[i] = addr; cfg_len[i] = len; cfg_size[i] = size;
        m_wr_i[i] = wr;
        m_addr_i[i*32 +: 32] = addr;
        m_len_i[i*LW +: LW]  = len;
        m_size_i[i*3 +: 3]   = size;
    endtask

    // Plays the bridge for one transaction and records what the arbiter showed.
    task automatic serve(input logic [NM-1:0] late_req, input int nbeats, input logic wr, input bit fast);
        bit found;
        int gap;
        found = 0; obs_timeout = 0; obs_spurious = 0; obs_aok = '0; obs_wbok = '0;
        q_dok.delete(); q_wbok.delete(); q_wlast.delete(); q_req.delete();
        q_wd.delete(); q_wdd.delete(); q_rd.delete(); q_rdd.delete(); q_rid.delete();
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk); #1;
            found = s_req_o;
        end
        if (!found) begin obs_timeout = 1; return; end
        m_req_i  = m_req_i | late_req;
        obs_rid  = s_rid_o;  obs_wr  = s_wr_o;  obs_awv  = s_awvalid_o;
        obs_addr = s_addr_o; obs_len = s_len_o; obs_size = s_size_o;
        gap = fast ? 0 : $urandom_range(0, 2);
        repeat (gap) begin
            @(negedge clk); #1;
            if (|m_addr_ok_o || |m_data_ok_o || |m_wb_ok_o || !s_req_o) obs_spurious++;
        end
        s_addr_ok_i = 1'b1; #1;
        obs_aok = m_addr_ok_o;
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            s_addr_ok_i = 1'b0; s_data_ok_i = 1'b0;
            gap = fast ? 0 : $urandom_range(0, 2);
            repeat (gap) begin
                #1;
                if (|m_addr_ok_o || |m_data_ok_o || |m_wb_ok_o) obs_spurious++;
                @(negedge clk);
            end
            for (int i = 0; i < NM; i++) m_wdata_i[i*32 +: 32] = $urandom;
            s_rdata_i = $urandom; s_data_ok_i = 1'b1; #1;
            q_dok.push_back(m_data_ok_o);  q_wbok.push_back(m_wb_ok_o);
            q_wlast.push_back(s_wlast_o);  q_req.push_back(s_req_o);
            q_wd.push_back(s_wdata_o);     q_wdd.push_back(m_wdata_i);
            q_rd.push_back(m_rdata_o);     q_rdd.push_back(s_rdata_i);
            q_rid.push_back(s_rid_o);
        end
        @(negedge clk);
        s_data_ok_i = 1'b0;
        if (wr) begin
            gap = fast ? 0 : $urandom_range(0, 2);
            repeat (gap) begin
                #1;
                if (|m_addr_ok_o || |m_data_ok_o || |m_wb_ok_o || !s_req_o) obs_spurious++;
                @(negedge clk);
            end
            s_wb_ok_i = 1'b1; #1;
            obs_wbok = m_wb_ok_o;
            @(negedge clk);
            s_wb_ok_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        m_req_i = '1; m_wr_i = '1; m_addr_i = {NM{32'hdead_beef}}; m_len_i = '1;
        #1;
        n_tests++; if (m_addr_ok_o !== '0) begin n_fail++; $display("FAIL rst_addr_ok got %b want 0", m_addr_ok_o); end
        n_tests++; if (m_data_ok_o !== '0) begin n_fail++; $display("FAIL rst_data_ok got %b want 0", m_data_ok_o); end
        n_tests++; if (m_wb_ok_o !== '0) begin n_fail++; $display("FAIL rst_wb_ok got %b want 0", m_wb_ok_o); end
        n_tests++; if (s_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_s_req got %b want 0", s_req_o); end
        n_tests++; if (s_awvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_awvalid got %b want 0", s_awvalid_o); end
        n_tests++; if (s_wlast_o !== 1'b0) begin n_fail++; $display("FAIL rst_wlast got %b want 0", s_wlast_o); end
        n_tests++; if (s_burst_o !== 2'b01) begin n_fail++; $display("FAIL rst_burst got %b want 01", s_burst_o); end
        @(negedge clk); #1;
        n_tests++; if (s_rid_o !== 4'd0) begin n_fail++; $display("FAIL rst_rid got %0d want 0", s_rid_o); end
        n_tests++; if (s_addr_o !== 32'd0) begin n_fail++; $display("FAIL rst_addr got %h want 0", s_addr_o); end
        n_tests++; if (s_len_o !== '0) begin n_fail++; $display("FAIL rst_len got %0d want 0", s_len_o); end
        n_tests++; if (s_wdata_o !== 32'd0) begin n_fail++; $display("FAIL rst_wdata got %h want 0", s_wdata_o); end
        n_tests++; if (s_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_hold_req got %b want 0", s_req_o); end
        @(negedge clk);
        m_req_i = '0; rst = 1'b0;
        model_reset();
    endtask

    // Master 1 write of four beats.
    task automatic test_write();
        int idle_bad;
        setm(1, 1'b1, $urandom & 32'hffff_fffc, 8'd3, 3'd2);
        m_req_i = 2'b10;
        serve('0, 4, 1'b1, 1'b0);
        m_req_i = '0;
        n_tests++; if (obs_timeout) begin n_fail++; $display("FAIL wr_timeout got timeout want request"); end
        n_tests++; if (obs_rid !== 4'd1) begin n_fail++; $display("FAIL wr_rid got %0d want 1", obs_rid); end
        n_tests++; if (obs_awv !== 1'b1 || obs_wr !== 1'b1) begin n_fail++; $display("FAIL wr_awvalid got %b/%b want 1/1", obs_awv, obs_wr); end
        n_tests++; if (obs_addr !== cfg_addr[1]) begin n_fail++; $display("FAIL wr_addr got %h want %h", obs_addr, cfg_addr[1]); end
        n_tests++; if (obs_aok !== 2'b10) begin n_fail++; $display("FAIL wr_addr_ok got %b want 10", obs_aok); end
        for (int b = 0; b < 4 && b < q_dok.size(); b++) begin
            n_tests++; if (q_dok[b] !== 2'b10) begin n_fail++; $display("FAIL wr_data_ok[%0d] got %b want 10", b, q_dok[b]); end
            n_tests++; if (q_wlast[b] !== (b == 3)) begin n_fail++; $display("FAIL wr_wlast[%0d] got %b want %b", b, q_wlast[b], b == 3); end
            n_tests++; if (q_wd[b] !== q_wdd[b][63:32]) begin n_fail++; $display("FAIL wr_wdata[%0d] got %h want %h", b, q_wd[b], q_wdd[b][63:32]); end
        end
        n_tests++; if (obs_wbok !== 2'b10) begin n_fail++; $display("FAIL wr_wb_ok got %b want 10", obs_wbok); end
        n_tests++; if (obs_spurious != 0) begin n_fail++; $display("FAIL wr_spurious got %0d want 0", obs_spurious); end
        idle_bad = 0;
        repeat (3) begin @(negedge clk); #1; if (s_req_o || |m_wb_ok_o) idle_bad++; end
        n_tests++; if (idle_bad != 0) begin n_fail++; $display("FAIL wr_idle got %0d busy cycles want 0", idle_bad); end
        model_done(1);
    endtask

    // Both masters keep requesting reads; grant order follows the configured policy.
    task automatic test_arbitration();
        int w;
        for (int i = 0; i < NM; i++) setm(i, 1'b0, $urandom & 32'hffff_fffc, LW'($urandom_range(0, 3)), 3'd2);
        m_req_i = '1;
        for (int t = 0; t < 6; t++) begin
            w = exp_winner(m_req_i);
            serve('0, int'(cfg_len[w]) + 1, 1'b0, 1'b0);
            n_tests++; if (obs_rid !== 4'(w)) begin n_fail++; $display("FAIL arb_grant[%0d] got %0d want %0d", t, obs_rid, w); end
            for (int b = 0; b < q_dok.size(); b++) begin
                n_tests++; if (q_dok[b] !== onehot(w)) begin n_fail++; $display("FAIL arb_data_ok[%0d.%0d] got %b want %b", t, b, q_dok[b], onehot(w)); end
            end
            model_done(w);
        end
        m_req_i = '0;
    endtask

    // m0 owns an 8-beat read while m1 starts requesting.
    task automatic test_lock();
        setm(0, 1'b0, $urandom & 32'hffff_fffc, 8'd7, 3'd2);
        setm(1, 1'b0, $urandom & 32'hffff_fffc, 8'd1, 3'd2);
        m_req_i = 2'b01;
        serve(2'b10, 8, 1'b0, 1'b0);
        m_req_i = '0;
        n_tests++; if (obs_aok !== 2'b01) begin n_fail++; $display("FAIL lock_addr_ok got %b want 01", obs_aok); end
        n_tests++; if (q_dok.size() != 8) begin n_fail++; $display("FAIL lock_beats got %0d want 8", q_dok.size()); end
        for (int b = 0; b < q_dok.size(); b++) begin
            n_tests++; if (q_dok[b] !== 2'b01) begin n_fail++; $display("FAIL lock_data_ok[%0d] got %b want 01", b, q_dok[b]); end
            n_tests++; if (q_rid[b] !== 4'd0) begin n_fail++; $display("FAIL lock_rid[%0d] got %0d want 0", b, q_rid[b]); end
        end
        n_tests++; if (q_wbok.size() == 8 && q_wbok[7] !== 2'b01) begin n_fail++; $display("FAIL lock_wb_ok got %b want 01", q_wbok[7]); end
        model_done(0);
    endtask

    task automatic test_random();
        int w, nb;
        logic [NM-1:0] req;
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < NM; i++)
                setm(i, 1'($urandom_range(0, 1)), $urandom & 32'hffff_fffc, LW'($urandom_range(0, 7)), 3'($urandom_range(0, 2)));
            req = NM'($urandom_range(1, (1 << NM) - 1));
            m_req_i = req;
            w  = exp_winner(req);
            nb = int'(cfg_len[w]) + 1;
            serve('0, nb, cfg_wr[w], 1'b0);
            m_req_i = '0;
            n_tests++; if (obs_timeout) begin n_fail++; $display("FAIL rnd_timeout[%0d] got timeout want request", t); end
            n_tests++; if (obs_rid !== 4'(w)) begin n_fail++; $display("FAIL rnd_rid[%0d] got %0d want %0d", t, obs_rid, w); end
            n_tests++; if (obs_wr !== cfg_wr[w] || obs_awv !== cfg_wr[w]) begin n_fail++; $display("FAIL rnd_wr[%0d] got %b/%b want %b", t, obs_wr, obs_awv, cfg_wr[w]); end
            n_tests++; if (obs_addr !== cfg_addr[w]) begin n_fail++; $display("FAIL rnd_addr[%0d] got %h want %h", t, obs_addr, cfg_addr[w]); end
            n_tests++; if (obs_len !== cfg_len[w] || obs_size !== cfg_size[w]) begin n_fail++; $display("FAIL rnd_attr[%0d] got %0d/%0d want %0d/%0d", t, obs_len, obs_size, cfg_len[w], cfg_size[w]); end
            n_tests++; if (obs_aok !== onehot(w)) begin n_fail++; $display("FAIL rnd_addr_ok[%0d] got %b want %b", t, obs_aok, onehot(w)); end
            for (int b = 0; b < q_dok.size(); b++) begin
                n_tests++; if (q_dok[b] !== onehot(w)) begin n_fail++; $display("FAIL rnd_data_ok[%0d.%0d] got %b want %b", t, b, q_dok[b], onehot(w)); end
                n_tests++; if (q_rd[b] !== q_rdd[b]) begin n_fail++; $display("FAIL rnd_rdata[%0d.%0d] got %h want %h", t, b, q_rd[b], q_rdd[b]); end
                n_tests++; if (q_req[b] !== cfg_wr[w]) begin n_fail++; $display("FAIL rnd_data_req[%0d.%0d] got %b want %b", t, b, q_req[b], cfg_wr[w]); end
                n_tests++; if (q_wlast[b] !== (cfg_wr[w] && b == nb - 1)) begin n_fail++; $display("FAIL rnd_wlast[%0d.%0d] got %b", t, b, q_wlast[b]); end
                if (cfg_wr[w]) begin
                    n_tests++; if (q_wd[b] !== q_wdd[b][w*32 +: 32]) begin n_fail++; $display("FAIL rnd_wdata[%0d.%0d] got %h want %h", t, b, q_wd[b], q_wdd[b][w*32 +: 32]); end
                end
                n_tests++; if (q_wbok[b] !== ((!cfg_wr[w] && b == nb - 1) ? onehot(w) : '0)) begin n_fail++; $display("FAIL rnd_read_wb_ok[%0d.%0d] got %b", t, b, q_wbok[b]); end
            end
            if (cfg_wr[w]) begin
                n_tests++; if (obs_wbok !== onehot(w)) begin n_fail++; $display("FAIL rnd_wb_ok[%0d] got %b want %b", t, obs_wbok, onehot(w)); end
            end
            n_tests++; if (obs_spurious != 0) begin n_fail++; $display("FAIL rnd_spurious[%0d] got %0d want 0", t, obs_spurious); end
            model_done(w);
        end
    endtask

    // Reset lands in the middle of a write burst owned by m1.
    task automatic test_reset_mid();
        bit found;
        int w;
        setm(0, 1'b0, $urandom & 32'hffff_fffc, 8'd0, 3'd2);
        m_req_i = 2'b01;
        serve('0, 1, 1'b0, 1'b0);
        m_req_i = '0;
        model_done(0);
        setm(1, 1'b1, $urandom & 32'hffff_fffc, 8'd3, 3'd2);
        m_req_i = 2'b10;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin @(negedge clk); #1; found = s_req_o; end
        n_tests++; if (!found) begin n_fail++; $display("FAIL rm_timeout got timeout want request"); end
        s_addr_ok_i = 1'b1;
        @(negedge clk); s_addr_ok_i = 1'b0; s_data_ok_i = 1'b1;
        @(negedge clk);
        @(negedge clk); s_data_ok_i = 1'b0; #1;
        n_tests++; if (s_req_o !== 1'b1 || s_wlast_o !== 1'b0) begin n_fail++; $display("FAIL rm_mid_burst got req=%b wlast=%b want 1/0", s_req_o, s_wlast_o); end
        rst = 1'b1; m_req_i = '0;
        @(negedge clk);
        rst = 1'b0; #1;
        n_tests++; if (|{m_addr_ok_o, m_data_ok_o, m_wb_ok_o}) begin n_fail++; $display("FAIL rm_handshakes got %b want 0", {m_addr_ok_o, m_data_ok_o, m_wb_ok_o}); end
        n_tests++; if (s_req_o !== 1'b0 || s_awvalid_o !== 1'b0 || s_wlast_o !== 1'b0) begin n_fail++; $display("FAIL rm_bridge got req=%b aw=%b wlast=%b want 0", s_req_o, s_awvalid_o, s_wlast_o); end
        n_tests++; if (s_rid_o !== 4'd0 || s_len_o !== '0) begin n_fail++; $display("FAIL rm_regs got rid=%0d len=%0d want 0", s_rid_o, s_len_o); end
        model_reset();
        for (int i = 0; i < NM; i++) setm(i, 1'b0, $urandom & 32'hffff_fffc, 8'd0, 3'd2);
        m_req_i = '1;
        w = exp_winner(m_req_i);
        serve('0, 1, 1'b0, 1'b0);
        m_req_i = '0;
        n_tests++; if (obs_rid !== 4'(w)) begin n_fail++; $display("FAIL rm_ptr_grant got %0d want %0d", obs_rid, w); end
        model_done(w);
    endtask

    // 256-beat read must end exactly on beat index 255.
    task automatic test_long();
        int dok1, dok0, wbn, wbat;
        setm(1, 1'b0, $urandom & 32'hffff_fffc, 8'd255, 3'd2);
        m_req_i = 2'b10;
        serve('0, 256, 1'b0, 1'b1);
        m_req_i = '0;
        dok1 = 0; dok0 = 0; wbn = 0; wbat = -1;
        foreach (q_dok[b]) begin
            if (q_dok[b][1]) dok1++;
            if (q_dok[b][0]) dok0++;
            if (|q_wbok[b]) begin wbn++; wbat = b; end
        end
        n_tests++; if (dok1 != 256) begin n_fail++; $display("FAIL long_beats got %0d want 256", dok1); end
        n_tests++; if (dok0 != 0) begin n_fail++; $display("FAIL long_other got %0d want 0", dok0); end
        n_tests++; if (wbn != 1 || wbat != 255) begin n_fail++; $display("FAIL long_wb_ok got %0d pulses at %0d want 1 at 255", wbn, wbat); end
        @(negedge clk); #1;
        n_tests++; if (s_req_o !== 1'b0) begin n_fail++; $display("FAIL long_idle got req=%b want 0", s_req_o); end
        model_done(1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_write();
        test_arbitration();
        test_lock();
        test_random();
        test_reset_mid();
        test_long();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
